// File: rtl/grid_pkg.sv
// Shared definitions for the 3x3 completion grid: cell geometry, completed colour,
// cell origin lookup and the scanner state encoding. The block drawer uses the same origins.
package grid_pkg;

    localparam int unsigned CELL_W      = 80;
    localparam int unsigned CELL_H      = 50;
    localparam int unsigned NUM_CELLS   = 9;
    localparam logic [2:0]  COLOUR_DONE = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    // Column position of a cell's top-left pixel; out-of-range indices map to 0.
    function automatic logic [9:0] cell_origin_x(input logic [3:0] idx);
        logic [9:0] x;
        case (idx)
            4'd0, 4'd3, 4'd6: x = 10'd152;
            4'd1, 4'd4, 4'd7: x = 10'd282;
            4'd2, 4'd5, 4'd8: x = 10'd412;
            default:          x = 10'd0;
        endcase
        return x;
    endfunction

    // Row position of a cell's top-left pixel; out-of-range indices map to 0.
    function automatic logic [8:0] cell_origin_y(input logic [3:0] idx);
        logic [8:0] y;
        case (idx)
            4'd0, 4'd1, 4'd2: y = 9'd226;
            4'd3, 4'd4, 4'd5: y = 9'd325;
            4'd6, 4'd7, 4'd8: y = 9'd425;
            default:          y = 9'd0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Raster col/row offset counter over a WIDTH x HEIGHT rectangle, column fastest.
// Exposes the offsets that follow the current position plus a flag for the final position.
module rect_scan_counter #(
    parameter int unsigned WIDTH  = 80,
    parameter int unsigned HEIGHT = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    output logic [9:0] col_nxt,
    output logic [8:0] row_nxt,
    output logic       last
);

    logic [9:0] col_r;
    logic [8:0] row_r;
    logic       col_last_s;
    logic       row_last_s;

    // Next-position arithmetic; both offsets wrap back to 0 after the final pixel.
    always_comb begin
        col_last_s = (col_r == 10'(WIDTH - 1));
        row_last_s = (row_r == 9'(HEIGHT - 1));
        last       = col_last_s && row_last_s;
        if (col_last_s) begin
            col_nxt = 10'd0;
            if (row_last_s) begin
                row_nxt = 9'd0;
            end else begin
                row_nxt = row_r + 9'd1;
            end
        end else begin
            col_nxt = col_r + 10'd1;
            row_nxt = row_r;
        end
    end

    // Offset registers: cleared at the start of a scan, advanced while enabled.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            col_r <= 10'd0;
            row_r <= 9'd0;
        end else if (en) begin
            col_r <= col_nxt;
            row_r <= row_nxt;
        end
    end

endmodule

// File: rtl/block_scanner.sv
// Scans one grid cell of the framebuffer through its read port and counts pixels of the
// completed colour, reporting the count, a fully-filled flag and an invalid-cell error.
module block_scanner
    import grid_pkg::*;
#(
    parameter int unsigned WIDTH         = CELL_W,
    parameter int unsigned HEIGHT        = CELL_H,
    parameter int unsigned RD_LATENCY    = 1,
    parameter logic [2:0]  TARGET_COLOUR = COLOUR_DONE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  block,
    output logic        rd_en,
    output logic [9:0]  rd_x,
    output logic [8:0]  rd_y,
    input  logic [2:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        filled,
    output logic [12:0] match_count,
    output logic        error
);

    localparam logic [12:0] CELL_PIXELS = 13'(WIDTH * HEIGHT);
    localparam logic [12:0] ACC_MAX     = 13'h1FFF;
    localparam logic [RD_LATENCY-1:0] VLD_TOP = RD_LATENCY'(1'b1) << (RD_LATENCY - 1);

    scan_state_e           state_r;
    logic [9:0]            origin_x_r;
    logic [8:0]            origin_y_r;
    logic [12:0]           acc_r;
    logic [12:0]           acc_nxt_s;
    logic [RD_LATENCY-1:0] vld_r;
    logic                  rd_en_r;
    logic [9:0]            rd_x_r;
    logic [8:0]            rd_y_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  filled_r;
    logic [12:0]           match_count_r;
    logic                  error_r;
    logic                  data_valid_s;
    logic                  drain_done_s;
    logic                  cnt_clr_s;
    logic                  cnt_en_s;
    logic [9:0]            col_nxt_s;
    logic [8:0]            row_nxt_s;
    logic                  last_s;

    assign rd_en       = rd_en_r;
    assign rd_x        = rd_x_r;
    assign rd_y        = rd_y_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign filled      = filled_r;
    assign match_count = match_count_r;
    assign error       = error_r;

    assign cnt_clr_s    = (state_r == ST_IDLE) && start;
    assign cnt_en_s     = (state_r == ST_ISSUE);
    assign data_valid_s = vld_r[RD_LATENCY-1];
    // The oldest read is the final one once nothing younger is still in flight.
    assign drain_done_s = data_valid_s && ((vld_r & ~VLD_TOP) == {RD_LATENCY{1'b0}});

    rect_scan_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clr_s),
        .en      (cnt_en_s),
        .col_nxt (col_nxt_s),
        .row_nxt (row_nxt_s),
        .last    (last_s)
    );

    // Saturating match accumulator input.
    always_comb begin
        acc_nxt_s = acc_r;
        if (data_valid_s && (rd_data == TARGET_COLOUR) && (acc_r != ACC_MAX)) begin
            acc_nxt_s = acc_r + 13'd1;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // In-flight read tracker, aligned with the framebuffer's read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_r <= {RD_LATENCY{1'b0}};
        end else begin
            vld_r[0] <= rd_en_r;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_r[i] <= vld_r[i-1];
            end
        end
    end

    // Scan control FSM with registered read-port and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            origin_x_r    <= 10'd0;
            origin_y_r    <= 9'd0;
            acc_r         <= 13'd0;
            rd_en_r       <= 1'b0;
            rd_x_r        <= 10'd0;
            rd_y_r        <= 9'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            filled_r      <= 1'b0;
            match_count_r <= 13'd0;
            error_r       <= 1'b0;
        end else begin
            acc_r  <= acc_nxt_s;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy_r <= 1'b1;
                        acc_r  <= 13'd0;
                        if (block < 4'(NUM_CELLS)) begin
                            state_r    <= ST_ISSUE;
                            origin_x_r <= cell_origin_x(block);
                            origin_y_r <= cell_origin_y(block);
                            rd_en_r    <= 1'b1;
                            rd_x_r     <= cell_origin_x(block);
                            rd_y_r     <= cell_origin_y(block);
                        end else begin
                            state_r       <= ST_DONE;
                            done_r        <= 1'b1;
                            error_r       <= 1'b1;
                            filled_r      <= 1'b0;
                            match_count_r <= 13'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (last_s) begin
                        state_r <= ST_DRAIN;
                        rd_en_r <= 1'b0;
                    end else begin
                        rd_x_r <= origin_x_r + col_nxt_s;
                        rd_y_r <= origin_y_r + row_nxt_s;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_s) begin
                        state_r       <= ST_DONE;
                        done_r        <= 1'b1;
                        error_r       <= 1'b0;
                        match_count_r <= acc_nxt_s;
                        filled_r      <= (acc_nxt_s == CELL_PIXELS);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_scanner.sv
// Scoreboard bench for block_scanner: two instances (read latency 1 and 3) behind a
// framebuffer model; stimulus queues expected results, a negedge monitor checks them.
module tb_block_scanner;

    typedef struct {
        int mc;
        int filled;
        int err;
        int lat;
        int t0;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  start_a;
    logic [3:0]  block_a   [2];
    logic [1:0]  rd_en_a;
    logic [9:0]  rd_x_a    [2];
    logic [8:0]  rd_y_a    [2];
    logic [2:0]  rd_data_a [2];
    logic [1:0]  busy_a;
    logic [1:0]  done_a;
    logic [1:0]  filled_a;
    logic [12:0] mc_a      [2];
    logic [1:0]  error_a;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   fb_mode;
    exp_t q0[$];
    exp_t q1[$];

    // Monitor-owned read tracking
    int rd_cnt[2] = '{0, 0};
    int addr_err[2] = '{0, 0};
    int first_x[2], first_y[2], last_x[2], last_y[2];
    // Stimulus-owned per-scan reference
    int base_cnt[2], base_err[2], exp_ox[2], exp_oy[2];

    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLACK = 3'b000;

    block_scanner #(.RD_LATENCY(1)) dut1 (
        .clock(clk), .reset(reset), .start(start_a[0]), .block(block_a[0]),
        .rd_en(rd_en_a[0]), .rd_x(rd_x_a[0]), .rd_y(rd_y_a[0]), .rd_data(rd_data_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .filled(filled_a[0]),
        .match_count(mc_a[0]), .error(error_a[0])
    );

    block_scanner #(.RD_LATENCY(3)) dut3 (
        .clock(clk), .reset(reset), .start(start_a[1]), .block(block_a[1]),
        .rd_en(rd_en_a[1]), .rd_x(rd_x_a[1]), .rd_y(rd_y_a[1]), .rd_data(rd_data_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .filled(filled_a[1]),
        .match_count(mc_a[1]), .error(error_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] pixel(input int mode, input int x, input int y);
        case (mode)
            1:       return GREEN;
            2:       return (x == 152 && y == 226) ? GREEN : BLACK;
            3:       return (x == 491 && y == 474) ? BLACK : GREEN;
            default: return BLACK;
        endcase
    endfunction

    // Framebuffer read pipelines; idle cycles return green so stray sampling is visible.
    logic       p0_en;
    logic [9:0] p0_x;
    logic [8:0] p0_y;
    logic [2:0] p1_en;
    logic [9:0] p1_x [3];
    logic [8:0] p1_y [3];
    initial begin
        p0_en = 1'b0;
        p1_en = 3'b000;
    end
    always @(posedge clk) begin
        p0_en   <= rd_en_a[0];
        p0_x    <= rd_x_a[0];
        p0_y    <= rd_y_a[0];
        p1_en   <= {p1_en[1:0], rd_en_a[1]};
        p1_x[0] <= rd_x_a[1];
        p1_y[0] <= rd_y_a[1];
        p1_x[1] <= p1_x[0];
        p1_y[1] <= p1_y[0];
        p1_x[2] <= p1_x[1];
        p1_y[2] <= p1_y[1];
    end
    assign rd_data_a[0] = p0_en    ? pixel(fb_mode, int'(p0_x), int'(p0_y))       : GREEN;
    assign rd_data_a[1] = p1_en[2] ? pixel(fb_mode, int'(p1_x[2]), int'(p1_y[2])) : GREEN;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: address order tracking and scoreboard comparison on every done pulse.
    int   mon_idx;
    exp_t mon_e;
    bit   mon_have;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rd_en_a[d]) begin
                mon_idx = rd_cnt[d] - base_cnt[d];
                if (int'(rd_x_a[d]) != exp_ox[d] + mon_idx % 80 ||
                    int'(rd_y_a[d]) != exp_oy[d] + mon_idx / 80)
                    addr_err[d]++;
                if (mon_idx == 0) begin
                    first_x[d] = int'(rd_x_a[d]);
                    first_y[d] = int'(rd_y_a[d]);
                end
                last_x[d] = int'(rd_x_a[d]);
                last_y[d] = int'(rd_y_a[d]);
                rd_cnt[d]++;
            end
            if (done_a[d]) begin
                mon_have = 1'b0;
                if (d == 0 && q0.size() > 0) begin
                    mon_e = q0.pop_front();
                    mon_have = 1'b1;
                end else if (d == 1 && q1.size() > 0) begin
                    mon_e = q1.pop_front();
                    mon_have = 1'b1;
                end
                if (!mon_have) begin
                    check($sformatf("unexpected_done_dut%0d", d), 1, 0);
                end else begin
                    check("match_count", int'(mc_a[d]), mon_e.mc);
                    check("filled", int'(filled_a[d]), mon_e.filled);
                    check("error", int'(error_a[d]), mon_e.err);
                    check("done_latency", cyc - mon_e.t0, mon_e.lat);
                    check("busy_at_done", int'(busy_a[d]), 1);
                end
            end
        end
    end

    // Issue one request (called at a negedge) and wait, bounded, for its done pulse.
    task automatic run_scan(input int d, input logic [3:0] blk, input int mc, input int filled,
                            input int err, input int lat, input int nreads,
                            input int ox, input int oy, input bit pulse);
        exp_t e;
        bit   got;
        base_cnt[d] = rd_cnt[d];
        base_err[d] = addr_err[d];
        exp_ox[d]   = ox;
        exp_oy[d]   = oy;
        start_a[d]  = 1'b1;
        block_a[d]  = blk;
        e.mc = mc; e.filled = filled; e.err = err; e.lat = lat; e.t0 = cyc;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        @(negedge clk);
        start_a[d] = 1'b0;
        block_a[d] = 4'd0;
        got = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            if (done_a[d]) begin
                got = 1'b1;
            end else begin
                start_a[d] = (pulse && i == 100);
                block_a[d] = (pulse && i == 100) ? 4'd12 : 4'd0;
                @(negedge clk);
            end
        end
        start_a[d] = 1'b0;
        check("done_seen", int'(got), 1);
        @(negedge clk);
        check("busy_after_done", int'(busy_a[d]), 0);
        check("done_one_cycle", int'(done_a[d]), 0);
        check("read_count", rd_cnt[d] - base_cnt[d], nreads);
        if (nreads > 0) begin
            check("addr_order_errors", addr_err[d] - base_err[d], 0);
            check("first_x", first_x[d], ox);
            check("first_y", first_y[d], oy);
            check("last_x", last_x[d], ox + 79);
            check("last_y", last_y[d], oy + 49);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start_a    = 2'b00;
        block_a[0] = 4'd0;
        block_a[1] = 4'd0;
        fb_mode    = 1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_rd_en", int'(rd_en_a[0]), 0);
        check("rst_rd_x", int'(rd_x_a[0]), 0);
        check("rst_rd_y", int'(rd_y_a[0]), 0);
        check("rst_busy", int'(busy_a[0]), 0);
        check("rst_done", int'(done_a[0]), 0);
        check("rst_filled", int'(filled_a[0]), 0);
        check("rst_match_count", int'(mc_a[0]), 0);
        check("rst_error", int'(error_a[0]), 0);
        @(negedge clk);

        // Invalid cell: immediate done with error, no reads
        fb_mode = 1;
        run_scan(0, 4'd12, 0, 0, 1, 1, 0, 0, 0, 1'b0);
        // Single green pixel at the cell-0 origin
        fb_mode = 2;
        run_scan(0, 4'd0, 1, 0, 0, 4002, 4000, 152, 226, 1'b0);
        // All green, centre cell
        fb_mode = 1;
        run_scan(0, 4'd4, 4000, 1, 0, 4002, 4000, 282, 325, 1'b0);
        // Latency 3, cell 8 with its last pixel not green
        fb_mode = 3;
        run_scan(1, 4'd8, 3999, 0, 0, 4004, 4000, 412, 425, 1'b0);

        // Reset in the middle of a scan
        fb_mode    = 1;
        start_a[0] = 1'b1;
        block_a[0] = 4'd2;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (1998) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_rd_en", int'(rd_en_a[0]), 0);
        check("midrst_busy", int'(busy_a[0]), 0);
        check("midrst_done", int'(done_a[0]), 0);
        check("midrst_match_count", int'(mc_a[0]), 0);
        check("midrst_filled", int'(filled_a[0]), 0);
        check("midrst_error", int'(error_a[0]), 0);
        repeat (4) @(negedge clk);
        // Clean restart with an ignored start pulse during the scan
        run_scan(0, 4'd2, 4000, 1, 0, 4002, 4000, 412, 226, 1'b1);

        repeat (10) @(negedge clk);
        check("scoreboard_empty_dut1", q0.size(), 0);
        check("scoreboard_empty_dut3", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/block_scanner.md
# block_scanner

Read-side counterpart to the block drawer. On request it scans one 80×50 cell of the 3×3 completion grid out of the 640×480, 3-bit colour framebuffer. It counts the pixels equal to the "completed" colour and reports whether the cell is fully filled. It sits between the game control FSM and the framebuffer's read port, so control can query grid state without keeping a shadow copy.

## Interface
Parameters:
- WIDTH, 80, cell width in pixels
- HEIGHT, 50, cell height in pixels
- RD_LATENCY, 1, cycles from rd_en to valid rd_data (1..4)
- TARGET_COLOUR, 3'b010, colour counted as filled (green)

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  request a scan; sampled only in IDLE
- block  in  4  cell index 0..8, sampled with start
- rd_en  out  1  framebuffer read strobe
- rd_x  out  10  read address x
- rd_y  out  9  read address y
- rd_data  in  3  pixel colour, valid RD_LATENCY cycles after rd_en
- busy  out  1  high from the accepting edge until done
- done  out  1  one-cycle pulse when the result is valid
- filled  out  1  all WIDTH*HEIGHT pixels matched TARGET_COLOUR
- match_count  out  13  number of matching pixels
- error  out  1  last request had block > 8

## Operation
- States:
  - IDLE → ISSUE on start with block ≤ 8.
  - IDLE → DONE on start with block > 8.
  - ISSUE → DRAIN after the last address is issued.
  - DRAIN → DONE when the last read data has been accumulated.
  - DONE → IDLE unconditionally.
- Cell origins (x, y):
  - 0 = (152, 226), 1 = (282, 226), 2 = (412, 226)
  - 3 = (152, 325), 4 = (282, 325), 5 = (412, 325)
  - 6 = (152, 425), 7 = (282, 425), 8 = (412, 425)
- Origin is latched at start. block changes during a scan have no effect.
- ISSUE drives rd_en = 1 every cycle in raster order: col 0..WIDTH-1 fastest, then row 0..HEIGHT-1.
  - rd_x = origin_x + col, rd_y = origin_y + row.
  - Width-exact adds; no wrap is possible for the legal cells (max x 491, max y 474).
- A RD_LATENCY-deep valid shift register tracks in-flight reads. Each valid rd_data equal to TARGET_COLOUR increments the accumulator (13 bits, saturates at 8191).
- In DONE:
  - match_count ← accumulator.
  - filled ← (accumulator == WIDTH*HEIGHT).
  - error ← 0 for a scan, 1 for an invalid block (in that case match_count = 0, filled = 0).
- Result outputs (filled, match_count, error) hold until the next DONE.
- start while busy is ignored; there is no queueing.

## Timing
- Reset values: rd_en = 0, rd_x = 0, rd_y = 0, busy = 0, done = 0, filled = 0, match_count = 0, error = 0; state IDLE.
- Valid scan, with start sampled at edge 0:
  - Cycle 1: ISSUE, first address, busy = 1.
  - Cycles 1..WIDTH*HEIGHT: one address per cycle, no gaps.
  - Cycle WIDTH*HEIGHT + RD_LATENCY + 1: done = 1 and results valid.
  - Default total: 4002 cycles from the start edge to done.
- Invalid block: done = 1 and error = 1 in cycle 1.
- busy deasserts in the cycle after done. A new start is accepted in that cycle.
- Reset mid-scan:
  - Next cycle is IDLE with rd_en = 0.
  - Accumulator and result registers are cleared.
  - Returning in-flight rd_data is discarded.
- rd_en is never asserted outside ISSUE.

## Structure
- Shared package `grid_pkg`:
  - cell origin lookup (function or constant arrays)
  - CELL_W / CELL_H
  - COLOUR_DONE = 3'b010
  - NUM_CELLS = 9
  - scanner state enum
- The drawer reuses the same package, so the origins stay identical.
- One sub-module: `rect_scan_counter`.
  - Col/row counters with enable.
  - Produces offsets plus a `last` flag.
- The FSM, the latency shift register and the accumulator live in block_scanner.

## Test plan
- Framebuffer model all green, block = 4 → done at cycle 4002, filled = 1, match_count = 4000, first address (282, 325), last address (361, 374).
- All black except one green pixel at (152, 226), block = 0 → filled = 0, match_count = 1.
- Cell 8 all green except pixel (491, 474), RD_LATENCY = 3 → match_count = 3999, done at cycle 4004, no missing or duplicate addresses.
- block = 12 → done at cycle 1 with error = 1, filled = 0, match_count = 0, rd_en never high.
- Reset asserted at cycle 2000, then start with block = 2 on an all-green buffer → clean restart, match_count = 4000. A start pulsed mid-scan is ignored.
